spi_flash_rd_sched: RTL and testbench

//  Sequences the byte-wide SPI flash read PHY on behalf of NREQ requesters (e.g. boot loader, I-fetch).

---
 rtl/spi_flash_pkg.sv | 15 +
 rtl/spi_flash_rr_arb.sv | 52 +++++
 rtl/spi_flash_rd_sched.sv | 179 +++++++++++++++++
 tb/tb_spi_flash_rd_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types for the SPI flash read scheduler: FSM state encoding and address width.
package spi_flash_pkg;

  localparam int SPI_ADDR_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT_BUSY,
    WAIT_DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_flash_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, searching from the entry after the last winner.
module spi_flash_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

  logic [PTR_W-1:0]  r_ptr;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PTR_W-1:0]  w_off;
  logic [PTR_W:0]    w_sum;
  logic [PTR_W:0]    w_idx_full;
  logic [PTR_W:0]    w_nxt_full;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_nxt;

  // Rotate so bit 0 is the highest-priority requester, then take the lowest set bit.
  assign w_dbl = {i_valid, i_valid} >> r_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PTR_W'(k);
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_idx_full = (w_sum >= NREQ_W) ? (w_sum - NREQ_W) : w_sum;
  assign w_idx      = w_idx_full[PTR_W-1:0];
  assign w_nxt_full = ({1'b0, w_idx} + 1'b1 >= NREQ_W) ? '0 : ({1'b0, w_idx} + 1'b1);
  assign w_nxt      = w_nxt_full[PTR_W-1:0];

  assign o_grant = (|i_valid) ? (NREQ'(1) << w_idx) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance && (|i_valid)) begin
      r_ptr <= w_nxt;
    end
  end

endmodule

// File: rtl/spi_flash_rd_sched.sv
// SPI flash read scheduler: round-robin requesters, byte-wise PHY reads assembled little-endian.
// Optional one-entry read cache enabled by defining SPI_FLASH_CACHE_EN.
module spi_flash_rd_sched
  import spi_flash_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int BYTES = 4
) (
  input  logic                         lsioc_clk_i,
  input  logic                         lsioc_rst_i,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ*SPI_ADDR_W-1:0]   req_addr_i,
  output logic [NREQ-1:0]              req_ready_o,
  output logic [NREQ-1:0]              rsp_valid_o,
  output logic [31:0]                  rsp_data_o,
  input  logic                         cache_inv_i,
  output logic [SPI_ADDR_W-1:0]        phy_addr_o,
  output logic                         phy_rd_o,
  input  logic                         phy_busy_i,
  input  logic [7:0]                   phy_data_i,
  input  logic                         phy_vld_i
);

  localparam logic [1:0] LAST_CNT = 2'(BYTES - 1);

  state_t                r_state;
  logic [NREQ-1:0]       r_win;
  logic [NREQ-1:0]       r_ready;
  logic [NREQ-1:0]       r_rsp_vld;
  logic [31:0]           r_rsp_data;
  logic                  r_rd;
  logic [SPI_ADDR_W-1:0] r_addr;
  logic [SPI_ADDR_W-1:0] r_base;
  logic [1:0]            r_cnt;
  logic [31:0]           r_asm;

  logic [NREQ-1:0]       w_grant;
  logic [SPI_ADDR_W-1:0] w_req_addr;
  logic [31:0]           w_asm_nxt;
  logic [31:0]           w_hit_data;
  logic                  w_any;
  logic                  w_win_vld;
  logic                  w_cap;
  logic                  w_last;
  logic                  w_hit;

  spi_flash_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk     (lsioc_clk_i),
    .i_rst     (lsioc_rst_i),
    .i_valid   (req_valid_i),
    .i_advance (r_state == IDLE),
    .o_grant   (w_grant)
  );

  assign w_any     = |req_valid_i;
  assign w_win_vld = |(req_valid_i & r_win);
  assign w_cap     = (r_state == WAIT_DATA) && phy_vld_i && !phy_busy_i;
  assign w_last    = (r_cnt == LAST_CNT);

  always_comb begin
    w_req_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_win[i]) w_req_addr = req_addr_i[SPI_ADDR_W*i +: SPI_ADDR_W];
    end
  end

  // Lanes at or above BYTES are never written, so they stay zero from GRANT.
  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[{r_cnt, 3'b000} +: 8] = phy_data_i;
  end

`ifdef SPI_FLASH_CACHE_EN
  logic                  r_c_vld;
  logic [SPI_ADDR_W-1:0] r_c_tag;
  logic [31:0]           r_c_data;

  always_ff @(posedge lsioc_clk_i) begin
    if (lsioc_rst_i) begin
      r_c_vld  <= 1'b0;
      r_c_tag  <= '0;
      r_c_data <= '0;
    end else begin
      if (w_cap && w_last) begin
        r_c_vld  <= 1'b1;
        r_c_tag  <= r_base;
        r_c_data <= w_asm_nxt;
      end
      // Invalidate wins over a same-cycle fill.
      if (cache_inv_i) r_c_vld <= 1'b0;
    end
  end

  assign w_hit      = r_c_vld && (r_c_tag == w_req_addr);
  assign w_hit_data = r_c_data;
`else
  logic w_unused_inv;
  assign w_unused_inv = cache_inv_i;
  assign w_hit        = 1'b0;
  assign w_hit_data   = '0;
`endif

  always_ff @(posedge lsioc_clk_i) begin
    if (lsioc_rst_i) begin
      r_state    <= IDLE;
      r_win      <= '0;
      r_ready    <= '0;
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_asm      <= '0;
    end else begin
      r_rd      <= 1'b0;
      r_ready   <= '0;
      r_rsp_vld <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_grant;
            r_ready <= w_grant;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_base <= w_req_addr;
          r_cnt  <= '0;
          r_asm  <= '0;
          // A requester that let go during its ready cycle is not served.
          if (!w_win_vld) begin
            r_state <= IDLE;
          end else if (w_hit) begin
            r_rsp_vld  <= r_win;
            r_rsp_data <= w_hit_data;
            r_state    <= DONE;
          end else begin
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!phy_busy_i) begin
            r_rd    <= 1'b1;
            r_addr  <= r_base + SPI_ADDR_W'(r_cnt);
            r_state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (phy_busy_i) r_state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (w_cap) begin
            r_asm <= w_asm_nxt;
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
              r_rsp_vld  <= r_win;
              r_rsp_data <= w_asm_nxt;
              r_state    <= DONE;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_vld;
  assign rsp_data_o  = r_rsp_data;
  assign phy_rd_o    = r_rd;
  assign phy_addr_o  = r_addr;

endmodule

// File: tb/tb_spi_flash_rd_sched.sv
// Self-checking bench for spi_flash_rd_sched with a behavioural PHY and request/response model.
// Cache checks are compiled in when SPI_FLASH_CACHE_EN is defined.
module tb_spi_flash_rd_sched;

  localparam int NREQ  = 2;
  localparam int BYTES = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*24-1:0]   req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_data;
  logic                 cache_inv;
  logic [23:0]          phy_addr;
  logic                 phy_rd;
  logic                 phy_busy;
  logic [7:0]           phy_data;
  logic                 phy_vld;

  int n_chk = 0;
  int n_err = 0;

  // PHY model knobs and strobe log
  int          lat_fixed = -1;
  bit          hold_vld  = 1'b0;
  int          phy_cnt   = 5;
  logic [23:0] phy_pend;
  logic [23:0] phy_q[$];

  // Reference model state
  int          ptr_m = 0;
  bit          c_vld_m = 1'b0;
  logic [23:0] c_tag_m = '0;

  always #5 clk = ~clk;

  spi_flash_rd_sched #(.NREQ(NREQ), .BYTES(BYTES)) dut (
    .lsioc_clk_i (clk),
    .lsioc_rst_i (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .cache_inv_i (cache_inv),
    .phy_addr_o  (phy_addr),
    .phy_rd_o    (phy_rd),
    .phy_busy_i  (phy_busy),
    .phy_data_i  (phy_data),
    .phy_vld_i   (phy_vld)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [23:0] d;
    d = a - 24'h100;
    if (a >= 24'h100 && a <= 24'h103) return 8'h11 * (d[7:0] + 8'd1);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < BYTES; k++) w |= 32'(byte_at(a + 24'(k))) << (8 * k);
    return w;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // PHY: a strobe raises busy, after a latency the byte appears with vld.
  // With hold_vld the vld level survives into the next transaction.
  always @(negedge clk) begin
    if (phy_rd) begin
      chk("rd_while_busy", {63'd0, phy_busy}, 64'd0);
      phy_q.push_back(phy_addr);
      phy_pend = phy_addr;
      phy_busy = 1'b1;
      phy_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      if (!hold_vld) phy_vld = 1'b0;
    end else if (phy_busy) begin
      if (phy_cnt == 0) begin
        phy_busy = 1'b0;
        phy_vld  = 1'b1;
        phy_data = byte_at(phy_pend);
      end else begin
        phy_cnt--;
      end
    end else if (!hold_vld) begin
      phy_vld = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready",   64'(req_ready), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_dat", 64'(rsp_data),  64'd0);
    chk("rst_phy_rd",  64'(phy_rd),    64'd0);
    chk("rst_phy_adr", 64'(phy_addr),  64'd0);
    rst     = 1'b0;
    ptr_m   = 0;
    c_vld_m = 1'b0;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g);
    int n;
    n = 0;
    g = '0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) break;
    end
    g = req_ready;
    if (g == '0) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  // Expects the model's winner to be granted, then checks the response and PHY strobes.
  task automatic grant_and_rsp(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] g;
    logic [23:0]     a;
    int              w, n;
    bit              hit;
    w = rr_pick(v, ptr_m);
    wait_grant(g);
    chk("grant", 64'(g), 64'(NREQ'(1) << w));
    ptr_m = (w + 1) % NREQ;
    a     = req_addr[24*w +: 24];
    hit   = c_vld_m && (c_tag_m == a);
    phy_q.delete();
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (rsp_valid != '0) break;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << w));
    chk("rsp_data",  64'(rsp_data),  64'(exp_word(a)));
    chk("n_strobes", 64'(phy_q.size()), hit ? 64'd0 : 64'(BYTES));
    if (!hit && phy_q.size() == BYTES) begin
      for (int k = 0; k < BYTES; k++) chk("phy_addr", 64'(phy_q[k]), 64'(a + 24'(k)));
    end
`ifdef SPI_FLASH_CACHE_EN
    c_vld_m = 1'b1;
    c_tag_m = a;
`endif
    @(negedge clk);
    chk("rsp_pulse", 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_req(input int r, input logic [23:0] a);
    logic [NREQ-1:0] v;
    v = NREQ'(1) << r;
    req_addr[24*r +: 24] = a;
    req_valid = v;
    fork
      begin
        @(negedge clk);
        while (req_ready == '0) @(negedge clk);
        @(negedge clk);
        req_valid = '0;
      end
      grant_and_rsp(v);
    join_any
    disable fork;
    req_valid = '0;
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    cache_inv = 1'b0;
    phy_busy  = 1'b1;
    phy_vld   = 1'b0;
    phy_data  = 8'h00;
    phy_pend  = '0;
    do_reset();

    // 1. single request, known data
    do_req(0, 24'h000100);

    // 2. both requesters valid continuously
    req_addr  = {24'h002000, 24'h001000};
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) grant_and_rsp(2'b11);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // 3. address wrap
    do_req(1, 24'hFFFFFE);

    // 4. PHY holds vld across strobes
    hold_vld = 1'b1;
    do_req(0, 24'h000500);
    do_req(1, 24'h123457);
    hold_vld = 1'b0;
    repeat (2) @(negedge clk);

    // 5. reset during WAIT_DATA of byte 2
    lat_fixed = 3;
    req_addr[23:0] = 24'h000300;
    req_valid = 2'b01;
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    phy_q.delete();
    n = 0;
    while (phy_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte2", 64'(phy_q.size()), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp",  64'(rsp_valid), 64'd0);
    chk("mid_rst_rdy",  64'(req_ready), 64'd0);
    chk("mid_rst_rd",   64'(phy_rd),    64'd0);
    chk("mid_rst_adr",  64'(phy_addr),  64'd0);
    chk("mid_rst_dat",  64'(rsp_data),  64'd0);
    rst     = 1'b0;
    ptr_m   = 0;
    c_vld_m = 1'b0;
    n = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (rsp_valid != '0) n++;
    end
    chk("no_rsp_after_rst", 64'(n), 64'd0);
    lat_fixed = -1;
    do_req(1, 24'h000400);

`ifdef SPI_FLASH_CACHE_EN
    // 6. cache hit, then invalidate
    do_req(0, 24'h000200);
    do_req(0, 24'h000200);
    @(negedge clk);
    cache_inv = 1'b1;
    @(negedge clk);
    cache_inv = 1'b0;
    c_vld_m   = 1'b0;
    do_req(1, 24'h000200);
`endif

    // randomized single requests
    for (int t = 0; t < 16; t++) begin
      logic [23:0] a;
      a = 24'($urandom);
      if (t % 4 == 3) a = 24'hFFFFFC + 24'($urandom_range(0, 3));
      hold_vld = 1'($urandom_range(0, 1));
      do_req(int'($urandom_range(0, NREQ - 1)), a);
    end
    hold_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", n_chk);
    $fatal(1, "bench timed out");
  end

endmodule
